// File: rtl/spi_master_controller_if.sv
// Command/response bundle between a command issuer and spi_master_controller.
interface spi_master_controller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;
    logic       err;

    // Command issuer side
    modport master (
        output cmd_valid,
        output cmd_type,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  done,
        input  err
    );

    // Controller side
    modport slave (
        input  cmd_valid,
        input  cmd_type,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output done,
        output err
    );
endinterface

// File: rtl/spi_master_controller.sv
// SPI master for the single-port-RAM SPI slave: serialises 10-bit command
// words (opcode + payload) MSB first on MOSI, frames them with SS_n and, for
// read-data commands, captures the returned RAM byte from MISO. The slave
// shares clk, so MOSI/MISO move one bit per clk cycle.
module spi_master_controller #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spi_master_controller_if.slave   bus,
    output logic                     SS_n,
    output logic                     MOSI,
    input  logic                     MISO
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SH_W  = 9;
    localparam int unsigned RX_W  = 7;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RECV  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [1:0] T_RD_ADDR = 2'b10;
    localparam logic [1:0] T_RD_DATA = 2'b11;

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(2);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(8);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT - 1);

    logic [2:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [SH_W-1:0]  sh_q,         sh_d;
    logic [1:0]       type_q,       type_d;
    logic [RX_W-1:0]  rx_q,         rx_d;
    logic             rd_pending_q, rd_pending_d;
    logic             ss_q,         ss_d;
    logic             mosi_q,       mosi_d;
    logic             ready_q,      ready_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [7:0]       rsp_data_q,   rsp_data_d;
    logic             done_q,       done_d;
    logic             err_q,        err_d;

    logic             seq_bad_c;

    // Read-address while a read is pending, or read-data with none pending
    assign seq_bad_c = ((bus.cmd_type == T_RD_ADDR) &&  rd_pending_q) ||
                       ((bus.cmd_type == T_RD_DATA) && !rd_pending_q);

    // Next-state and next-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        type_d       = type_q;
        rx_d         = rx_q;
        rd_pending_d = rd_pending_q;
        ss_d         = ss_q;
        mosi_d       = mosi_q;
        ready_d      = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (seq_bad_c) begin
                        // Rejected: no frame, SS_n stays high
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        type_d  = bus.cmd_type;
                        sh_d    = {bus.cmd_type[0], bus.cmd_data};
                        ss_d    = 1'b0;
                        mosi_d  = bus.cmd_type[1];
                        cnt_d   = '0;
                        state_d = S_PRE;
                    end
                end
            end

            S_PRE: begin
                // word[9] is held while the slave leaves IDLE and samples direction
                if (cnt_q == PRE_LAST) begin
                    mosi_d  = sh_q[SH_W-1];
                    sh_d    = {sh_q[SH_W-2:0], 1'b0};
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    mosi_d = 1'b0;
                    cnt_d  = '0;
                    if (type_q == T_RD_DATA) begin
                        state_d = S_WAIT;
                    end else begin
                        ss_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_GAP;
                        if (type_q == T_RD_ADDR) begin
                            rd_pending_d = 1'b1;
                        end
                    end
                end else begin
                    mosi_d = sh_q[SH_W-1];
                    sh_d   = {sh_q[SH_W-2:0], 1'b0};
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT: begin
                // Slave and RAM turnaround before the first MISO bit
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RECV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RECV: begin
                rx_d = {rx_q[RX_W-2:0], MISO};
                if (cnt_q == RECV_LAST) begin
                    rsp_data_d   = {rx_q, MISO};
                    rsp_valid_d  = 1'b1;
                    done_d       = 1'b1;
                    ss_d         = 1'b1;
                    rd_pending_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                // One cycle with SS_n high so the slave returns to IDLE
                ready_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            type_q       <= '0;
            rx_q         <= '0;
            rd_pending_q <= 1'b0;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b0;
            ready_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            type_q       <= type_d;
            rx_q         <= rx_d;
            rd_pending_q <= rd_pending_d;
            ss_q         <= ss_d;
            mosi_q       <= mosi_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign SS_n          = ss_q;
    assign MOSI          = mosi_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Directed bench for spi_master_controller: frame traces are packed one bit
// per cycle (after E0 first, shifted in) and compared to hand-computed values.
module tb_spi_master_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic ss0, mosi0, miso0;
    logic ss4, mosi4, miso4;

    spi_master_controller_if ifc0();
    spi_master_controller_if ifc4();

    spi_master_controller #(.RD_WAIT(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0),
        .SS_n  (ss0),
        .MOSI  (mosi0),
        .MISO  (miso0)
    );

    spi_master_controller #(.RD_WAIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc4),
        .SS_n  (ss4),
        .MOSI  (mosi4),
        .MISO  (miso4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       sel = 1'b0;
    logic       m_ss, m_mosi, m_rdy, m_rv, m_done, m_err;
    logic [7:0] m_rd;

    assign m_ss   = sel ? ss4            : ss0;
    assign m_mosi = sel ? mosi4          : mosi0;
    assign m_rdy  = sel ? ifc4.cmd_ready : ifc0.cmd_ready;
    assign m_rv   = sel ? ifc4.rsp_valid : ifc0.rsp_valid;
    assign m_rd   = sel ? ifc4.rsp_data  : ifc0.rsp_data;
    assign m_done = sel ? ifc4.done      : ifc0.done;
    assign m_err  = sel ? ifc4.err       : ifc0.err;

    logic [31:0] v_ss, v_mosi, v_done, v_err, v_rv, v_rdy;
    logic [7:0]  v_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [1:0] t, input logic [7:0] d);
        if (s) begin
            ifc4.cmd_valid = v; ifc4.cmd_type = t; ifc4.cmd_data = d;
        end else begin
            ifc0.cmd_valid = v; ifc0.cmd_type = t; ifc0.cmd_data = d;
        end
    endtask

    task automatic set_miso(input logic s, input logic b);
        if (s) miso4 = b;
        else   miso0 = b;
    endtask

    // Issue one command, then trace len cycles (after E0 .. after E(len-1))
    task automatic run_frame(input logic s, input logic [1:0] t, input logic [7:0] d,
                             input logic [7:0] mb, input int rw, input int len);
        int k;
        sel = s;
        k = 0;
        @(negedge clk);
        while (!m_rdy && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(m_rdy), 32'd1);
        drive(s, 1'b1, t, d);
        @(posedge clk);
        v_ss = '0; v_mosi = '0; v_done = '0; v_err = '0; v_rv = '0; v_rdy = '0; v_rd = '0;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (j == 0) drive(s, 1'b0, 2'b00, 8'h00);
            v_ss   = {v_ss[30:0],   m_ss};
            v_mosi = {v_mosi[30:0], m_mosi};
            v_done = {v_done[30:0], m_done};
            v_err  = {v_err[30:0],  m_err};
            v_rv   = {v_rv[30:0],   m_rv};
            v_rdy  = {v_rdy[30:0],  m_rdy};
            if (m_rv) v_rd = m_rd;
            // MISO bit for the sample on the following edge
            if (j >= 12 + rw && j < 20 + rw) set_miso(s, mb[3'(19 + rw - j)]);
            else                             set_miso(s, 1'b0);
        end
    endtask

    // Every frame ends with two SS_n-high cycles, done on the first, ready on the second
    task automatic check_frame(input string tag, input logic [31:0] e_mosi,
                               input logic e_err, input logic e_rv, input logic [7:0] e_rd);
        check({tag, ".ss"},        v_ss,   32'h3);
        check({tag, ".mosi"},      v_mosi, e_mosi);
        check({tag, ".done"},      v_done, 32'h2);
        check({tag, ".err"},       v_err,  e_err ? 32'h2 : 32'h0);
        check({tag, ".rsp_valid"}, v_rv,   e_rv  ? 32'h2 : 32'h0);
        check({tag, ".ready"},     v_rdy,  32'h1);
        if (e_rv) check({tag, ".rsp_data"}, 32'(v_rd), 32'(e_rd));
    endtask

    int acc [3];
    int n_acc;
    logic ss_tr [64];
    int hi1, hi2, k;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        miso0 = 1'b0;
        miso4 = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        drive(1'b1, 1'b0, 2'b00, 8'h00);
        repeat (3) @(negedge clk);

        // Reset values
        check("rst.ss",        32'(ss0),            32'd1);
        check("rst.mosi",      32'(mosi0),          32'd0);
        check("rst.ready",     32'(ifc0.cmd_ready), 32'd0);
        check("rst.rsp_valid", 32'(ifc0.rsp_valid), 32'd0);
        check("rst.rsp_data",  32'(ifc0.rsp_data),  32'd0);
        check("rst.done",      32'(ifc0.done),      32'd0);
        check("rst.err",       32'(ifc0.err),       32'd0);
        rst_n = 1'b1;

        // Read-data with nothing pending is rejected
        run_frame(1'b0, 2'b11, 8'h00, 8'h00, 2, 2);
        check_frame("rd_no_addr", 32'h0, 1'b1, 1'b0, 8'h00);

        // Write address 0x5A: word 0x05A
        run_frame(1'b0, 2'b00, 8'h5A, 8'h00, 2, 14);
        check_frame("wr_addr", 32'h168, 1'b0, 1'b0, 8'h00);

        // Write data 0xC3: word 0x1C3
        run_frame(1'b0, 2'b01, 8'hC3, 8'h00, 2, 14);
        check_frame("wr_data", 32'h70C, 1'b0, 1'b0, 8'h00);

        // Read address 0x5A: word 0x25A
        run_frame(1'b0, 2'b10, 8'h5A, 8'h00, 2, 14);
        check_frame("rd_addr", 32'h3968, 1'b0, 1'b0, 8'h00);

        // Second read address while pending is rejected
        run_frame(1'b0, 2'b10, 8'h5A, 8'h00, 2, 2);
        check_frame("rd_addr_twice", 32'h0, 1'b1, 1'b0, 8'h00);

        // Read data returns the RAM byte 0xC3
        run_frame(1'b0, 2'b11, 8'h00, 8'hC3, 2, 24);
        check_frame("rd_data", 32'hF00000, 1'b0, 1'b1, 8'hC3);

        // Pending cleared by the read-data frame
        run_frame(1'b0, 2'b11, 8'h00, 8'h00, 2, 2);
        check_frame("rd_data_again", 32'h0, 1'b1, 1'b0, 8'h00);

        // Reset in the middle of a write frame
        sel = 1'b0;
        @(negedge clk);
        k = 0;
        while (!ifc0.cmd_ready && k < 64) begin @(negedge clk); k++; end
        drive(1'b0, 1'b1, 2'b00, 8'h11);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        repeat (5) @(negedge clk);
        check("mid.ss_before", 32'(ss0), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid.ss",    32'(ss0),            32'd1);
        check("mid.mosi",  32'(mosi0),          32'd0);
        check("mid.done",  32'(ifc0.done),      32'd0);
        check("mid.ready", 32'(ifc0.cmd_ready), 32'd0);
        @(negedge clk);
        check("mid.done2", 32'(ifc0.done),      32'd0);
        rst_n = 1'b1;

        // Full read sequence after the abort: address 0x3C, byte 0x96
        run_frame(1'b0, 2'b10, 8'h3C, 8'h00, 2, 14);
        check_frame("post_rst_rd_addr", 32'h38F0, 1'b0, 1'b0, 8'h00);
        run_frame(1'b0, 2'b11, 8'h00, 8'h96, 2, 24);
        check_frame("post_rst_rd_data", 32'hF00000, 1'b0, 1'b1, 8'h96);

        // Back-to-back writes with cmd_valid held
        sel = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 8'h33);
        n_acc = 0;
        for (int c = 0; c < 64; c++) begin
            if (n_acc == 3 && ifc0.cmd_valid) drive(1'b0, 1'b0, 2'b00, 8'h00);
            ss_tr[c] = ss0;
            if (ifc0.cmd_ready && ifc0.cmd_valid && n_acc < 3) begin
                acc[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        check("b2b.accepts", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            check("b2b.gap1", 32'(acc[1] - acc[0]), 32'd14);
            check("b2b.gap2", 32'(acc[2] - acc[1]), 32'd14);
            hi1 = 0;
            hi2 = 0;
            for (int c = acc[0] + 1; c <= acc[1]; c++) if (ss_tr[c]) hi1++;
            for (int c = acc[1] + 1; c <= acc[2] && c < 64; c++) if (ss_tr[c]) hi2++;
            check("b2b.ss_high1", 32'(hi1), 32'd2);
            check("b2b.ss_high2", 32'(hi2), 32'd2);
        end

        // RD_WAIT=4 instance: address 0x01 then read byte 0xA5
        run_frame(1'b1, 2'b10, 8'h01, 8'h00, 4, 14);
        check_frame("w4_rd_addr", 32'h3804, 1'b0, 1'b0, 8'h00);
        run_frame(1'b1, 2'b11, 8'h00, 8'hA5, 4, 26);
        check_frame("w4_rd_data", 32'h3C00000, 1'b0, 1'b1, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
